// File: rtl/board_pkg.sv
// board_pkg: shared definitions for the board pick-and-drop controller.
//   - default board geometry (squares per side, square size, origin, coordinate width)
//   - control FSM state encoding
//   - idx_width(): square index width for a given board size
package board_pkg;

  localparam int DEF_BOARD_N  = 8;
  localparam int DEF_SQ_SIZE  = 64;
  localparam int DEF_ORIGIN_X = 256;
  localparam int DEF_ORIGIN_Y = 128;
  localparam int DEF_COORD_W  = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_QUERY = 3'd1,
    ST_CHECK = 3'd2,
    ST_HELD  = 3'd3,
    ST_REQ   = 3'd4
  } pick_state_e;

  // Width of a square index for a board_n x board_n board (at least 1 bit).
  function automatic int idx_width(input int board_n);
    return (board_n * board_n > 1) ? $clog2(board_n * board_n) : 1;
  endfunction

endpackage

// File: rtl/board_pick_ctrl_if.sv
// board_pick_ctrl_if: move request handshake from the pick controller to the
// board-state logic.
//   mv_valid  master -> slave  a move request is pending
//   mv_ready  slave  -> master the board-state logic accepts it this cycle
//   mv_from   master -> slave  source square index
//   mv_to     master -> slave  destination square index
// The payload is held stable while mv_valid=1; mv_valid only drops after a
// cycle with mv_valid & mv_ready (or on reset).
interface board_pick_ctrl_if #(
  parameter int IDX_W = board_pkg::idx_width(board_pkg::DEF_BOARD_N)
);
  logic             mv_valid;
  logic             mv_ready;
  logic [IDX_W-1:0] mv_from;
  logic [IDX_W-1:0] mv_to;

  modport master (output mv_valid, output mv_from, output mv_to, input mv_ready);
  modport slave  (input mv_valid, input mv_from, input mv_to, output mv_ready);
endinterface

// File: rtl/square_mapper.sv
// square_mapper: free-running mouse-position to board-square mapper.
// One update period is BOARD_N+2 cycles:
//   cnt 0          : sample xpos/ypos, remove the origin, run the in-board test
//   cnt 1..BOARD_N : one restoring-subtraction step of SQ_SIZE on x and y in parallel
//   cnt BOARD_N+1  : publish hover_valid / hover_idx = row*BOARD_N + col, restart
// Repeated subtraction keeps SQ_SIZE free of any power-of-two restriction.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   xpos, ypos      mouse position (already in the clk domain)
//   hover_valid     cursor is inside the board
//   hover_idx       square under the cursor, 0 when outside
module square_mapper import board_pkg::*; #(
  parameter int BOARD_N  = DEF_BOARD_N,
  parameter int SQ_SIZE  = DEF_SQ_SIZE,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int IDX_W    = idx_width(DEF_BOARD_N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  output logic               hover_valid,
  output logic [IDX_W-1:0]   hover_idx
);

  localparam int CNT_W = $clog2(BOARD_N + 2);
  localparam int CW    = $clog2(BOARD_N + 1);
  localparam int X_END = ORIGIN_X + BOARD_N * SQ_SIZE;
  localparam int Y_END = ORIGIN_Y + BOARD_N * SQ_SIZE;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BOARD_N + 1);
  localparam logic [COORD_W-1:0] SQ       = COORD_W'(SQ_SIZE);
  localparam logic [COORD_W-1:0] OX       = COORD_W'(ORIGIN_X);
  localparam logic [COORD_W-1:0] OY       = COORD_W'(ORIGIN_Y);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [CW-1:0]      col_q, col_d, row_q, row_d;
  logic               inb_q, inb_d;
  logic               hover_valid_q, hover_valid_d;
  logic [IDX_W-1:0]   hover_idx_q, hover_idx_d;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    cnt_d         = cnt_q;
    rem_x_d       = rem_x_q;
    rem_y_d       = rem_y_q;
    col_d         = col_q;
    row_d         = row_q;
    inb_d         = inb_q;
    hover_valid_d = hover_valid_q;
    hover_idx_d   = hover_idx_q;

    if (cnt_q == '0) begin
      // Remainders are only meaningful when inb_d=1; out-of-board wraparound is discarded.
      rem_x_d = xpos - OX;
      rem_y_d = ypos - OY;
      col_d   = '0;
      row_d   = '0;
      inb_d   = (int'(xpos) >= ORIGIN_X) && (int'(xpos) < X_END) &&
                (int'(ypos) >= ORIGIN_Y) && (int'(ypos) < Y_END);
      cnt_d   = CNT_W'(1);
    end else if (cnt_q != CNT_LAST) begin
      if (rem_x_q >= SQ) begin
        rem_x_d = rem_x_q - SQ;
        col_d   = col_q + CW'(1);
      end
      if (rem_y_q >= SQ) begin
        rem_y_d = rem_y_q - SQ;
        row_d   = row_q + CW'(1);
      end
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      hover_valid_d = inb_q;
      hover_idx_d   = inb_q ? (IDX_W'(row_q) * IDX_W'(BOARD_N) + IDX_W'(col_q)) : '0;
      cnt_d         = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q         <= '0;
      rem_x_q       <= '0;
      rem_y_q       <= '0;
      col_q         <= '0;
      row_q         <= '0;
      inb_q         <= 1'b0;
      hover_valid_q <= 1'b0;
      hover_idx_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      rem_x_q       <= rem_x_d;
      rem_y_q       <= rem_y_d;
      col_q         <= col_d;
      row_q         <= row_d;
      inb_q         <= inb_d;
      hover_valid_q <= hover_valid_d;
      hover_idx_q   <= hover_idx_d;
    end
  end

  assign hover_valid = hover_valid_q;
  assign hover_idx   = hover_idx_q;

endmodule

// File: rtl/board_pick_ctrl.sv
// board_pick_ctrl: mouse-driven piece pick-and-drop controller.
// Maps the mouse onto the board (square_mapper), qualifies a press against the
// occupancy lookup, holds the picked piece and issues a from/to move request.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   xpos, ypos            mouse position (already in the clk domain)
//   lmb                   left mouse button level
//   query_idx / query_occ occupancy lookup; query_occ valid 1 cycle after query_idx
//   hover_valid/hover_idx square under the cursor
//   held / held_idx       a piece is held, and its source square
//   mv                    move request handshake (master side)
// Build option: BOARD_PICK_CANCEL_EN - when defined, a drop outside the board or
// on the source square cancels the pick; otherwise such a drop is ignored and
// the piece stays held.
module board_pick_ctrl import board_pkg::*; #(
  parameter int BOARD_N  = DEF_BOARD_N,
  parameter int SQ_SIZE  = DEF_SQ_SIZE,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int COORD_W  = DEF_COORD_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [COORD_W-1:0]            xpos,
  input  logic [COORD_W-1:0]            ypos,
  input  logic                          lmb,
  output logic [idx_width(BOARD_N)-1:0] query_idx,
  input  logic                          query_occ,
  output logic                          hover_valid,
  output logic [idx_width(BOARD_N)-1:0] hover_idx,
  output logic                          held,
  output logic [idx_width(BOARD_N)-1:0] held_idx,
  board_pick_ctrl_if.master             mv
);

  localparam int IDX_W = idx_width(BOARD_N);

  square_mapper #(
    .BOARD_N (BOARD_N),
    .SQ_SIZE (SQ_SIZE),
    .ORIGIN_X(ORIGIN_X),
    .ORIGIN_Y(ORIGIN_Y),
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W)
  ) u_mapper (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .hover_valid(hover_valid),
    .hover_idx  (hover_idx)
  );

  pick_state_e      state_q, state_d;
  logic             lmb_q, lmb_dly_q;
  logic [IDX_W-1:0] query_idx_q, query_idx_d;
  logic             held_q, held_d;
  logic [IDX_W-1:0] held_idx_q, held_idx_d;
  logic [IDX_W-1:0] mv_from_q, mv_from_d;
  logic [IDX_W-1:0] mv_to_q, mv_to_d;
  logic             pend_q, pend_d;
  logic             press_evt, rel_evt;

  // Edges of the once-registered button level.
  assign press_evt = lmb_q & ~lmb_dly_q;
  assign rel_evt   = ~lmb_q & lmb_dly_q;

  always_comb begin
    state_d     = state_q;
    query_idx_d = query_idx_q;
    held_d      = held_q;
    held_idx_d  = held_idx_q;
    mv_from_d   = mv_from_q;
    mv_to_d     = mv_to_q;
    pend_d      = pend_q;

    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (press_evt && hover_valid) begin
          query_idx_d = hover_idx;
          state_d     = ST_QUERY;
        end
      end
      ST_QUERY: begin
        // Occupancy answer arrives next cycle; remember a quick release meanwhile.
        if (rel_evt) pend_d = 1'b1;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (query_occ) begin
          held_d     = 1'b1;
          held_idx_d = query_idx_q;
          pend_d     = pend_q | rel_evt;
          state_d    = ST_HELD;
        end else begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        pend_d = 1'b0;
        if (rel_evt || pend_q) begin
          if (hover_valid && (hover_idx != held_idx_q)) begin
            mv_from_d = held_idx_q;
            mv_to_d   = hover_idx;
            state_d   = ST_REQ;
          end else begin
`ifdef BOARD_PICK_CANCEL_EN
            held_d  = 1'b0;
            state_d = ST_IDLE;
`endif
          end
        end
      end
      ST_REQ: begin
        // Button edges are ignored here; only the handshake can leave REQ.
        if (mv.mv_ready) begin
          held_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lmb_q       <= 1'b0;
      lmb_dly_q   <= 1'b0;
      query_idx_q <= '0;
      held_q      <= 1'b0;
      held_idx_q  <= '0;
      mv_from_q   <= '0;
      mv_to_q     <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lmb_q       <= lmb;
      lmb_dly_q   <= lmb_q;
      query_idx_q <= query_idx_d;
      held_q      <= held_d;
      held_idx_q  <= held_idx_d;
      mv_from_q   <= mv_from_d;
      mv_to_q     <= mv_to_d;
      pend_q      <= pend_d;
    end
  end

  assign query_idx  = query_idx_q;
  assign held       = held_q;
  assign held_idx   = held_idx_q;
  assign mv.mv_valid = (state_q == ST_REQ);
  assign mv.mv_from  = mv_from_q;
  assign mv.mv_to    = mv_to_q;

endmodule

// File: doc/board_pick_ctrl.md
# board_pick_ctrl

Mouse-driven piece pick-and-drop controller for the chess display. Maps the synchronised mouse position onto a parametrised square board, qualifies picks against board occupancy, and issues move requests (from/to square index) to the board-state logic over a valid/ready handshake. It sits between the mouse position register stage and `chess_board`, and replaces the fixed-geometry mouse-to-square mapping.

## Interface
- `BOARD_N`, 8, squares per side.
- `SQ_SIZE`, 64, square edge in pixels; any value ≥1, not restricted to powers of two.
- `ORIGIN_X`, 256, pixel x of the board's left edge.
- `ORIGIN_Y`, 128, pixel y of the board's top edge.
- `COORD_W`, 12, mouse coordinate width.
- `IDX_W` (localparam), `$clog2(BOARD_N*BOARD_N)`, square index width.
- `clk` in 1: single clock, the pixel clock domain.
- `rst` in 1: reset, synchronous, active-low.
- `xpos`, `ypos` in `COORD_W`: mouse position, already synchronised to `clk`.
- `lmb` in 1: left mouse button level.
- `query_idx` out `IDX_W`: square index presented to the occupancy lookup.
- `query_occ` in 1: occupancy of `query_idx`, valid exactly 1 cycle after `query_idx` is driven.
- `hover_valid` out 1: cursor is inside the board.
- `hover_idx` out `IDX_W`: square under the cursor; 0 when `hover_valid`=0.
- `held` out 1: a piece is currently held.
- `held_idx` out `IDX_W`: source square of the held piece.
- `mv_valid` out 1, `mv_ready` in 1: move handshake.
- `mv_from`, `mv_to` out `IDX_W`: move payload.

## Operation
- Mapper runs continuously. It samples `xpos`/`ypos`, subtracts the origin, then computes col and row in parallel by repeated subtraction of `SQ_SIZE`, at most `BOARD_N` iterations. It then writes `hover_idx = row*BOARD_N + col` and restarts.
- Outside the board means x < `ORIGIN_X`, x ≥ `ORIGIN_X+BOARD_N*SQ_SIZE`, or the same test in y. In that case `hover_valid`=0 and `hover_idx`=0.
- `lmb` is registered once; press and release are detected as edges of the registered level.
- Control FSM states: IDLE, QUERY, CHECK, HELD, REQ.
- IDLE: on press with `hover_valid`=1, latch `hover_idx` into `query_idx` and go to QUERY. A press with `hover_valid`=0 is ignored.
- QUERY: wait 1 cycle, then go to CHECK.
- CHECK: if `query_occ`=1, set `held_idx`=`query_idx` and `held`=1, then go to HELD. Otherwise return to IDLE.
- A release seen during QUERY or CHECK sets a pending-release flag. On entry to HELD the flag acts as a release; a failed CHECK clears it.
- HELD: on release, if `hover_valid`=1 and `hover_idx`≠`held_idx`, latch `mv_from`=`held_idx` and `mv_to`=`hover_idx`, then go to REQ. Any other drop is handled as described under Configuration.
- REQ: `mv_valid`=1. When `mv_valid`&`mv_ready`, clear `held` and return to IDLE. Button edges in REQ are ignored.
- Handshake: `mv_from`/`mv_to` stay stable while `mv_valid`=1. `mv_valid` never drops without `mv_ready`.

## Timing
- Reset: every output is 0, FSM in IDLE, mapper restarts. Asserting reset during REQ drops `mv_valid` on the next edge, with no transfer.
- Mapper latency: `BOARD_N`+2 cycles from sample to `hover_idx` update, for a maximum of 10 at default. Update period is identical.
- Press to `held`=1: 4 cycles (edge register, IDLE, QUERY, CHECK).
- Release to `mv_valid`=1: 2 cycles.
- Handshake completion to IDLE: 1 cycle. A new press is accepted from the following cycle.

## Configuration
- `BOARD_PICK_CANCEL_EN` defined: a drop outside the board or on the source square cancels the pick. `held` clears and the FSM returns to IDLE with no request.
- `BOARD_PICK_CANCEL_EN` undefined: such a drop is ignored. The FSM stays in HELD and the next valid release produces the move.

## Structure
- `board_pkg` holds the FSM state enum typedef, the default geometry constants, and an index-width helper function.
- One sub-module, `square_mapper`, contains the iterative coordinate-to-index divider and the in-board test. The FSM and handshake stay in `board_pick_ctrl`.

## Test plan
All scenarios use default parameters.
- Mouse at (300,140) → `hover_valid`=1, `hover_idx`=0. At (760,600) → `hover_idx`=63. At (255,200) → `hover_valid`=0, `hover_idx`=0.
- Press at (300,140) with `query_occ`=1, release at (400,200) → `held`=1 with `held_idx`=0, then `mv_valid`=1 with `mv_from`=0, `mv_to`=10.
- In REQ, `mv_ready`=0 for 5 cycles, then 1 → `mv_valid` high throughout with payload stable; the FSM is in IDLE one cycle after acceptance.
- Press on a square with `query_occ`=0 → `held` stays 0 and no request is issued.
- Release at (100,100) or on the source square → with the macro, `held`=0 and no request; without it, `held` stays 1. A later release at (400,200) then yields `mv_to`=10.
- Press, then release one cycle later during QUERY → the pending release is honoured. Separately, `rst`=0 while in REQ → next cycle `mv_valid`=0, `held`=0, FSM in IDLE.
